uart_boot_ctrl: RTL and testbench

//  Sequences program download from the UART receiver into instruction memory.

---
 rtl/boot_pkg.sv | 35 +++
 rtl/boot_timeout_cnt.sv | 36 +++
 rtl/uart_boot_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and helpers for the UART boot loader: FSM states, error codes,
// handshake bytes and the CRC-8 (poly 0x07) update used on the download stream.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } boot_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CRC     = 2'b01,
        ERR_LEN     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } boot_err_e;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // One byte of CRC-8, MSB first, no reflection, no final xor.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// Inter-byte gap counter: counts enabled idle cycles and flags the cycle in
// which the LIMIT-th consecutive idle cycle is reached.
module boot_timeout_cnt #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot controller: receives a framed image, writes it word by word into imem
// and holds the core in reset until the CRC checks out. BOOT_ECHO_EN adds a byte echo/ACK/NAK port.
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              imem_sel_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic [1:0]        err_o,
`ifdef BOOT_ECHO_EN
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ready_i,
`endif
    output logic [2:0]        state_o
);

    boot_state_e       state_q, state_d;
    boot_err_e         err_q, err_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        crc_q, crc_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       len_n;
    logic              in_frame, rx_sync, gap_expired;

    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == PAYLOAD) || (state_q == CHK);
    assign rx_sync  = rx_valid_i && (rx_data_i == SYNC_BYTE);
    assign len_n    = {rx_data_i, len_lo_q};

    boot_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_gap (
        .clk       (clk),
        .reset     (reset),
        .en_i      (in_frame),
        .clr_i     (rx_valid_i),
        .expired_o (gap_expired)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        crc_d      = crc_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        we_d       = 1'b0;

        // The address advances in the cycle after each write strobe.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE, ERR: begin
                if (rx_sync) begin
                    state_d    = LEN_LO;
                    err_d      = ERR_NONE;
                    crc_d      = 8'h00;
                    byte_idx_d = 2'd0;
                    addr_d     = '0;
                end
            end
            LEN_LO: begin
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    crc_d    = crc8_step(crc_q, rx_data_i);
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid_i) begin
                    len_d = len_n;
                    crc_d = crc8_step(crc_q, rx_data_i);
                    if (32'(len_n) > (32'd1 << ADDR_W)) begin
                        state_d = ERR;
                        err_d   = ERR_LEN;
                    end else if (len_n == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid_i) begin
                    crc_d = crc8_step(crc_q, rx_data_i);
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d = 1'b1;
                        if ((32'(addr_q) + 32'd1) == 32'(len_q)) begin
                            state_d = CHK;
                        end
                    end
                end
            end
            CHK: begin
                if (rx_valid_i) begin
                    if (rx_data_i == crc_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_CRC;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A byte arriving in the expiry cycle has already been consumed above.
        if (in_frame && gap_expired && !rx_valid_i) begin
            state_d = ERR;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            len_lo_q   <= 8'h00;
            len_q      <= 16'h0000;
            crc_q      <= 8'h00;
            byte_idx_q <= 2'd0;
            wdata_q    <= 32'h0000_0000;
            addr_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
        end
    end

    // The core stays in reset in ERR too: imem holds a corrupt image there.
    assign imem_sel_o   = in_frame || (state_q == DONE);
    assign cpu_reset_o  = reset || (state_q != IDLE);
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign state_o      = state_q;

`ifdef BOOT_ECHO_EN
    logic       tx_valid_q, resp_pend_q;
    logic [7:0] tx_data_q, resp_byte_q;
    logic       rx_accept, slot_free;

    assign rx_accept = rx_valid_i && (in_frame || (rx_sync && ((state_q == IDLE) || (state_q == ERR))));
    assign slot_free = !tx_valid_q || tx_ready_i;

    // Echo bytes win the slot; the ACK/NAK waits until the slot frees up.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            resp_pend_q <= 1'b0;
            resp_byte_q <= 8'h00;
        end else begin
            if (tx_valid_q && tx_ready_i) begin
                tx_valid_q <= 1'b0;
            end
            if (slot_free && rx_accept) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= rx_data_i;
            end else if (slot_free && resp_pend_q) begin
                tx_valid_q  <= 1'b1;
                tx_data_q   <= resp_byte_q;
                resp_pend_q <= 1'b0;
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                resp_pend_q <= 1'b1;
                resp_byte_q <= ACK_BYTE;
            end else if ((state_d == ERR) && (state_q != ERR)) begin
                resp_pend_q <= 1'b1;
                resp_byte_q <= NAK_BYTE;
            end
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
`else
    // Without the echo path frame bytes are consumed silently.
`endif

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl: good/bad CRC, oversize length, gap timeout
// at and just past the expiry cycle, mid-frame reset, and the optional echo port.
module tb_uart_boot_ctrl;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned TMO    = 20;
    localparam logic [2:0] S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_PAYLOAD = 3'd3,
                           S_CHK = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              imem_sel, imem_we, cpu_reset, done;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [1:0]        err;
    logic [2:0]        state;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int spurious_we = 0;
    int done_base;
    logic [7:0] tb_crc;
    logic [ADDR_W+31:0] exp_q[$];

`ifdef BOOT_ECHO_EN
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic [7:0] got_tx[$];
    int         tx_base;
    logic [7:0] exp_tx[13];
`endif

    uart_boot_ctrl #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .imem_sel_o   (imem_sel),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_reset_o  (cpu_reset),
        .done_o       (done),
        .err_o        (err),
`ifdef BOOT_ECHO_EN
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .tx_ready_i   (tx_ready),
`endif
        .state_o      (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-8 reference, poly 0x07.
    function automatic logic [7:0] crc_bits(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Imem write scoreboard and done-pulse counter, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() != 0) begin
                check_eq("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
            end else begin
                spurious_we++;
            end
        end
        if (done) done_cnt++;
    end

`ifdef BOOT_ECHO_EN
    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
    end
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_gap(input int gap, input logic [7:0] b);
        repeat (gap) @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_gap(1, b);
    endtask

    task automatic send_c(input logic [7:0] b);
        tb_crc = crc_bits(tb_crc, b);
        send(b);
    endtask

    task automatic sync_b();
        tb_crc = 8'h00;
        send(8'hA5);
    endtask

    // Two-word image 0x00000013, 0x00100093; crc_delta corrupts the CRC byte.
    task automatic frame1(input logic [7:0] crc_delta);
        exp_q.push_back({ADDR_W'(0), 32'h0000_0013});
        exp_q.push_back({ADDR_W'(1), 32'h0010_0093});
        sync_b();
        check_eq("sync_state", 64'(state), 64'(S_LEN_LO));
        check_eq("sync_sel", 64'(imem_sel), 64'd1);
        check_eq("sync_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("sync_err_clear", 64'(err), 64'd0);
        send_c(8'h02);
        send_c(8'h00);
        check_eq("len_state", 64'(state), 64'(S_PAYLOAD));
        send_c(8'h13); send_c(8'h00); send_c(8'h00); send_c(8'h00);
        check_eq("we_latency", 64'(imem_we), 64'd1);
        send_c(8'h93); send_c(8'h00); send_c(8'h10); send_c(8'h00);
        check_eq("chk_state", 64'(state), 64'(S_CHK));
        send(tb_crc + crc_delta);
    endtask

    initial begin
        // Reset values
        tick(3);
        check_eq("rst_sel", 64'(imem_sel), 64'd0);
        check_eq("rst_we", 64'(imem_we), 64'd0);
        check_eq("rst_addr", 64'(imem_addr), 64'd0);
        check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
        check_eq("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_state", 64'(state), 64'(S_IDLE));
        reset = 1'b0;
        tick(2);

        // Non-SYNC byte in IDLE is ignored
        send(8'h5A);
        check_eq("idle_ignore", 64'(state), 64'(S_IDLE));

        // Test 1: good image
        done_base = done_cnt;
        frame1(8'h00);
        check_eq("t1_done", 64'(done), 64'd1);
        check_eq("t1_done_state", 64'(state), 64'(S_DONE));
        check_eq("t1_done_cpu_reset", 64'(cpu_reset), 64'd1);
        tick(1);
        check_eq("t1_done_pulse", 64'(done), 64'd0);
        check_eq("t1_cpu_release", 64'(cpu_reset), 64'd0);
        check_eq("t1_sel_release", 64'(imem_sel), 64'd0);
        check_eq("t1_idle", 64'(state), 64'(S_IDLE));
        check_eq("t1_done_count", 64'(done_cnt - done_base), 64'd1);

        // Test 2: CRC off by one
        done_base = done_cnt;
        frame1(8'h01);
        tick(2);
        check_eq("t2_err", 64'(err), 64'd1);
        check_eq("t2_state", 64'(state), 64'(S_ERR));
        check_eq("t2_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("t2_sel", 64'(imem_sel), 64'd0);
        check_eq("t2_no_done", 64'(done_cnt - done_base), 64'd0);

        // Test 3: oversize length, SYNC leaves ERR and clears err
        sync_b();
        check_eq("t3_err_cleared", 64'(err), 64'd0);
        send_c(8'h01);
        send_c(8'h80);
        check_eq("t3_err_len", 64'(err), 64'd2);
        check_eq("t3_state", 64'(state), 64'(S_ERR));
        check_eq("t3_cpu_reset", 64'(cpu_reset), 64'd1);

        // Largest legal length is accepted; SYNC inside the frame is plain data
        sync_b();
        send_c(8'h00);
        send_c(8'h40);
        check_eq("max_len_state", 64'(state), 64'(S_PAYLOAD));
        check_eq("max_len_err", 64'(err), 64'd0);
        send(8'hA5);
        check_eq("sync_as_data", 64'(state), 64'(S_PAYLOAD));
        reset = 1'b1;
        tick(1);
        check_eq("abort_state", 64'(state), 64'(S_IDLE));
        reset = 1'b0;
        tick(1);

        // Test 4: silence for TMO idle clocks after two payload bytes
        sync_b();
        send_c(8'h01); send_c(8'h00);
        send_c(8'h11); send_c(8'h22);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check_eq("t4_before_expiry", 64'(state), 64'(S_PAYLOAD));
        tick(1);
        check_eq("t4_err_timeout", 64'(err), 64'd3);
        check_eq("t4_state", 64'(state), 64'(S_ERR));

        // Byte landing exactly in the expiry cycle keeps the frame alive
        done_base = done_cnt;
        exp_q.push_back({ADDR_W'(0), 32'h4433_2211});
        sync_b();
        send_c(8'h01); send_c(8'h00);
        send_c(8'h11); send_c(8'h22);
        tb_crc = crc_bits(tb_crc, 8'h33);
        send_gap(TMO - 1, 8'h33);
        check_eq("t4b_state", 64'(state), 64'(S_PAYLOAD));
        check_eq("t4b_err", 64'(err), 64'd0);
        send_c(8'h44);
        send(tb_crc);
        tick(1);
        check_eq("t4b_done", 64'(done_cnt - done_base), 64'd1);

        // Test 5: reset after the 5th payload byte
        exp_q.push_back({ADDR_W'(0), 32'h0000_0013});
        sync_b();
        send_c(8'h02); send_c(8'h00);
        send_c(8'h13); send_c(8'h00); send_c(8'h00); send_c(8'h00); send_c(8'h93);
        reset = 1'b1;
        tick(1);
        check_eq("t5_sel", 64'(imem_sel), 64'd0);
        check_eq("t5_we", 64'(imem_we), 64'd0);
        check_eq("t5_addr", 64'(imem_addr), 64'd0);
        check_eq("t5_wdata", 64'(imem_wdata), 64'd0);
        check_eq("t5_cpu_reset", 64'(cpu_reset), 64'd1);
        check_eq("t5_done", 64'(done), 64'd0);
        check_eq("t5_err", 64'(err), 64'd0);
        check_eq("t5_state", 64'(state), 64'(S_IDLE));
        reset = 1'b0;
        tick(1);
        send(8'hA5); send(8'h00); send(8'h00);
        check_eq("t5_n0_chk", 64'(state), 64'(S_CHK));
        send(8'h00);
        check_eq("t5_n0_done", 64'(done), 64'd1);
        tick(1);
        check_eq("t5_cpu_release", 64'(cpu_reset), 64'd0);

`ifdef BOOT_ECHO_EN
        // Test 6: echo of every frame byte, then ACK / NAK
        tx_base = got_tx.size();
        frame1(8'h00);
        tick(4);
        exp_tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, tb_crc, 8'h06};
        check_eq("t6_echo_len", 64'(got_tx.size() - tx_base), 64'd13);
        for (int i = 0; i < 13; i++) begin
            if (tx_base + i < got_tx.size()) begin
                check_eq("t6_echo_byte", 64'(got_tx[tx_base + i]), 64'(exp_tx[i]));
            end
        end
        tx_base = got_tx.size();
        frame1(8'h01);
        tick(4);
        check_eq("t6_nak_len", 64'(got_tx.size() - tx_base), 64'd13);
        if (got_tx.size() != 0) begin
            check_eq("t6_nak", 64'(got_tx[got_tx.size() - 1]), 64'h15);
        end
`endif

        tick(2);
        check_eq("spurious_we", 64'(spurious_we), 64'd0);
        check_eq("writes_pending", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
